fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the RV32I pipeline: owns the PC, issues word fetches to instruction memory,
//  buffers in-order responses in a small FIFO and drives the IF/ID register into decode.
//  Consumes stall/flush from the hazard/control unit. On a taken branch it redirects the PC
//  and discards wrong-path fetches, including those still in flight.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH  2              response buffer entries; power of 2, >=2; also max outstanding
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   asynchronous, active-low reset
//  stall_i        in   1   hold IF/ID register (load-use stall from control unit)
//  flush_i        in   1   branch/jump taken: squash wrong path, redirect PC
//  flush_pc_i     in   32  redirect target, sampled when flush_i=1
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  32  fetch address, word aligned
//  imem_gnt_i     in   1   request accepted this cycle when imem_req_o & imem_gnt_i
//  imem_rvalid_i  in   1   response valid; in order, >=1 cycle after grant
//  imem_rdata_i   in   32  instruction word
//  ID_valid_o     out  1   IF/ID register holds a real instruction
//  ID_instr_o     out  32  IF/ID instruction (NOP 32'h0000_0013 when invalid)
//  ID_pc_o        out  32  IF/ID PC of ID_instr_o
//  ID_exc_o       out  1   instruction-address-misaligned (FETCH_MISALIGN_EXC_EN only, else 0)
// BEHAVIOUR
//  Reset: pc=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req_o=0, ID_valid_o=0,
//   ID_instr_o=NOP, ID_pc_o=0, ID_exc_o=0. First request in 1st cycle after reset release.
//  FSM: BOOT (1 cycle after reset) -> RUN; RUN -> HALT on misaligned redirect (macro only);
//   HALT -> RUN on next aligned flush. HALT issues no requests.
//  Issue: imem_req_o=1 in RUN when outstanding+fifo_count < FIFO_DEPTH (credit rule: every
//   response always has a slot; no backpressure on rvalid). imem_addr_o=pc.
//   On grant pc<=pc+4 (wraps mod 2^32), outstanding++. Req/addr stable until granted.
//  Response: rvalid & discard==0 -> push {pc_of_req, rdata}; rvalid & discard>0 -> drop,
//   discard--. Either way outstanding--. Request PC kept in a parallel FIFO_DEPTH tag queue.
//  IF/ID: if !stall_i: ID_valid_o<=!fifo_empty; pop head into ID_instr_o/ID_pc_o, else NOP.
//   FIFO bypass allowed: rvalid into empty FIFO may load IF/ID same edge (latency grant->ID = 1
//   cycle + memory latency). stall_i: IF/ID and pop frozen; FIFO still fills, requests per credit.
//  Flush (highest priority, wins over stall_i and same-cycle rvalid/grant):
//   pc<=flush_pc_i; FIFO cleared; discard<=outstanding (+1 if grant this cycle, -1 if rvalid this
//   cycle); ID_valid_o<=0, ID_instr_o<=NOP. Requests to new PC start next cycle, even while
//   discard>0. Back-to-back flushes accumulate discard correctly.
//  Counters sized $clog2(FIFO_DEPTH)+1; never overflow by credit rule (bench asserts).
//  Reset mid-operation: all state to reset values immediately; later stray rvalid with
//   outstanding==0 is ignored (assertion flags it).
// CONFIGURATION
//  FETCH_MISALIGN_EXC_EN defined: flush_pc_i[1:0]!=0 -> no fetch; next non-stalled cycle
//   ID_valid_o=1, ID_exc_o=1, ID_pc_o=flush_pc_i, ID_instr_o=NOP; FSM->HALT until next flush.
//  Not defined: flush_pc_i[1:0] forced to 0, ID_exc_o tied 0, HALT state absent.
// TESTING
//  1 Reset release, gnt=1, 1-cycle mem -> addresses 0,4,8...; ID_pc_o 0,4,8 on consecutive cycles.
//  2 stall_i=1 for 3 cycles mid-stream -> ID_pc_o held; <=FIFO_DEPTH extra grants; no loss/dup.
//  3 flush_i with 2 outstanding, flush_pc_i=0x100 -> both responses dropped; next ID_pc_o=0x100.
//  4 flush_i & stall_i & rvalid same cycle -> ID_valid_o=0 next cycle; rvalid data dropped.
//  5 gnt random 50%, rvalid latency 1..4 -> ID stream matches sequential PCs, no overrun.
//  6 Macro on: flush_pc_i=0x102 -> ID_exc_o=1, ID_pc_o=0x102, imem_req_o=0 until flush to 0x200.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the IF stage. The master is the fetch unit and the slave is the memory.
`timescale 1ns/1ps
interface fetch_stage_if;
  // Request: the master holds imem_req_o/imem_addr_o stable until a cycle with imem_req_o & imem_gnt_i.
  // Response: imem_rvalid_i is in order, arrives >=1 cycle after grant, and is never backpressured.
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC, credit-limited fetch issue, in-order response FIFO with tag queue, IF/ID register.
// Optional macro FETCH_MISALIGN_EXC_EN adds a misaligned-redirect exception and a HALT state.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [31:0]   flush_pc_i,
  fetch_stage_if.master imem,
  output logic          ID_valid_o,
  output logic [31:0]   ID_instr_o,
  output logic [31:0]   ID_pc_o,
  output logic          ID_exc_o,
  output logic [1:0]    dbg_state_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1
`ifdef FETCH_MISALIGN_EXC_EN
    , S_HALT = 2'd2
`endif
  } state_t;

  state_t        r_state, w_next_state;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_out, r_discard, r_cnt;
  logic [AW-1:0] r_wr, r_rd, r_tag_wr, r_tag_rd;
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_tag        [FIFO_DEPTH];
  logic          r_id_valid;
  logic [31:0]   r_id_instr, r_id_pc;

  logic          w_req, w_gnt_fire, w_rv, w_keep, w_load_ok, w_bypass, w_push, w_pop;
  logic [31:0]   w_flush_target;
  logic [CW-1:0] w_out_nxt;

`ifdef FETCH_MISALIGN_EXC_EN
  logic r_exc_pending, r_id_exc, w_misalign;
  assign w_misalign     = flush_i & (flush_pc_i[1:0] != 2'b00);
  assign w_flush_target = flush_pc_i;
`else
  assign w_flush_target = flush_pc_i & 32'hFFFF_FFFC;
`endif

  // Responses arriving with outstanding==0 are strays (e.g. after a mid-flight reset) and are ignored.
  assign w_gnt_fire = w_req & imem.imem_gnt_i;
  assign w_rv       = imem.imem_rvalid_i & (r_out != '0);
  assign w_keep     = w_rv & (r_discard == '0) & ~flush_i;
  assign w_load_ok  = ~flush_i & ~stall_i;
  assign w_bypass   = w_load_ok & (r_cnt == '0) & w_keep;
  assign w_push     = w_keep & ~w_bypass;
  assign w_pop      = w_load_ok & (r_cnt != '0);
  assign w_out_nxt  = r_out + CW'(w_gnt_fire) - CW'(w_rv);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_BOOT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT: begin
        w_next_state = S_RUN;
`ifdef FETCH_MISALIGN_EXC_EN
        if (w_misalign) w_next_state = S_HALT;
`endif
      end
      S_RUN: begin
`ifdef FETCH_MISALIGN_EXC_EN
        if (w_misalign) w_next_state = S_HALT;
`endif
      end
`ifdef FETCH_MISALIGN_EXC_EN
      S_HALT: if (flush_i && !w_misalign) w_next_state = S_RUN;
`endif
      default: w_next_state = S_BOOT;
    endcase
  end

  // Credit rule: a request is only issued when its response is guaranteed a FIFO slot.
  always_comb begin
    w_req = 1'b0;
    if (r_state == S_RUN && (r_out + r_cnt) < DEPTH_C) w_req = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc      <= RESET_PC;
      r_out     <= '0;
      r_discard <= '0;
      r_cnt     <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_tag_wr  <= '0;
      r_tag_rd  <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (w_gnt_fire) r_tag_wr <= r_tag_wr + AW'(1);
      if (w_rv)       r_tag_rd <= r_tag_rd + AW'(1);
      if (flush_i) begin
        // Everything still in flight after this edge belongs to the wrong path.
        r_pc      <= w_flush_target;
        r_discard <= w_out_nxt;
        r_cnt     <= '0;
        r_wr      <= '0;
        r_rd      <= '0;
      end else begin
        if (w_gnt_fire) r_pc <= r_pc + 32'd4;
        if (w_rv && r_discard != '0) r_discard <= r_discard - CW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        if (w_push) r_wr <= r_wr + AW'(1);
        if (w_pop)  r_rd <= r_rd + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_gnt_fire) r_tag[r_tag_wr] <= r_pc;
    if (w_push) begin
      r_fifo_instr[r_wr] <= imem.imem_rdata_i;
      r_fifo_pc[r_wr]    <= r_tag[r_tag_rd];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP;
      r_id_pc    <= 32'h0;
`ifdef FETCH_MISALIGN_EXC_EN
      r_id_exc      <= 1'b0;
      r_exc_pending <= 1'b0;
`endif
    end else if (flush_i) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP;
`ifdef FETCH_MISALIGN_EXC_EN
      r_id_exc      <= 1'b0;
      r_exc_pending <= w_misalign;
`endif
    end else if (!stall_i) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP;
`ifdef FETCH_MISALIGN_EXC_EN
      r_id_exc      <= 1'b0;
      r_exc_pending <= 1'b0;
      if (r_exc_pending) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= r_pc;
        r_id_exc   <= 1'b1;
      end else
`endif
      if (r_cnt != '0) begin
        r_id_valid <= 1'b1;
        r_id_instr <= r_fifo_instr[r_rd];
        r_id_pc    <= r_fifo_pc[r_rd];
      end else if (w_keep) begin
        r_id_valid <= 1'b1;
        r_id_instr <= imem.imem_rdata_i;
        r_id_pc    <= r_tag[r_tag_rd];
      end
    end
  end

  assign imem.imem_req_o  = w_req;
  assign imem.imem_addr_o = r_pc;
  assign ID_valid_o       = r_id_valid;
  assign ID_instr_o       = r_id_instr;
  assign ID_pc_o          = r_id_pc;
  assign dbg_state_o      = r_state;
`ifdef FETCH_MISALIGN_EXC_EN
  assign ID_exc_o = r_id_exc;
`else
  assign ID_exc_o = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model tags each grant with a flush epoch, monitor checks IF/ID.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i;
  logic [31:0] flush_pc_i;
  logic        ID_valid_o, ID_exc_o;
  logic [31:0] ID_instr_o, ID_pc_o;
  logic [1:0]  dbg_state_o;

  fetch_stage_if imem_bus();

  fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .flush_pc_i(flush_pc_i), .imem(imem_bus),
    .ID_valid_o(ID_valid_o), .ID_instr_o(ID_instr_o), .ID_pc_o(ID_pc_o),
    .ID_exc_o(ID_exc_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  req_t        pend[$];
  req_t        r_pop;
  logic [64:0] exp_q[$];
  logic [64:0] e;
  int n_checks = 0, n_fail = 0, n_seen = 0, cyc = 0, epoch = 0, stall_grants = 0;
  int lat_min = 1, lat_max = 1;
  bit gnt_rand = 0, stall_win = 0, prev_stall = 0, prev_flush = 0, wait_req = 0;
  logic [31:0] exp_addr = RST_PC, wait_addr = 32'h0;
  logic        last_valid = 1'b0;
  logic [31:0] last_instr = NOP, last_pc = 32'h0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0033;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference bookkeeping: address sequence, credit bound, and which responses must reach decode.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      pend.delete(); exp_q.delete();
      cyc = 0; epoch = 0; exp_addr = RST_PC;
      prev_stall = 0; prev_flush = 0; wait_req = 0;
    end else begin
      cyc++;
      if (wait_req) begin
        chk("req_held", 32'(imem_bus.imem_req_o), 32'd1);
        chk("addr_held", imem_bus.imem_addr_o, wait_addr);
      end
      if (imem_bus.imem_rvalid_i) begin
        if (pend.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rvalid_no_req: response with nothing pending (cycle %0d)", cyc);
        end else begin
          r_pop = pend.pop_front();
          if (r_pop.epoch == epoch && !flush_i)
            exp_q.push_back({1'b0, r_pop.addr, instr_of(r_pop.addr)});
        end
      end
      if (imem_bus.imem_req_o && imem_bus.imem_gnt_i) begin
        chk("imem_addr", imem_bus.imem_addr_o, exp_addr);
        exp_addr = exp_addr + 32'd4;
        pend.push_back('{imem_bus.imem_addr_o, epoch, cyc + int'($urandom_range(lat_min, lat_max))});
        chk("credit", 32'(pend.size() <= DEPTH), 32'd1);
        if (stall_win) stall_grants++;
      end
      wait_req  = imem_bus.imem_req_o && !imem_bus.imem_gnt_i && !flush_i;
      wait_addr = imem_bus.imem_addr_o;
      if (flush_i) begin
        epoch++;
        exp_q.delete();
`ifdef FETCH_MISALIGN_EXC_EN
        exp_addr = flush_pc_i;
        if (flush_pc_i[1:0] != 2'b00) exp_q.push_back({1'b1, flush_pc_i, NOP});
`else
        exp_addr = {flush_pc_i[31:2], 2'b00};
`endif
      end
      prev_stall = stall_i;
      prev_flush = flush_i;
    end
  end

  // Memory driver: grant policy plus in-order responses after each request's latency.
  initial begin
    imem_bus.imem_gnt_i    = 1'b0;
    imem_bus.imem_rvalid_i = 1'b0;
    imem_bus.imem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk_i); #1;
      imem_bus.imem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_i && pend.size() != 0 && pend[0].due <= cyc + 1) begin
        imem_bus.imem_rvalid_i = 1'b1;
        imem_bus.imem_rdata_i  = instr_of(pend[0].addr);
      end else begin
        imem_bus.imem_rvalid_i = 1'b0;
        imem_bus.imem_rdata_i  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: each fresh IF/ID load pops the scoreboard; stalls must hold, flushes must squash.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (prev_flush) begin
        chk("flush_squash_valid", 32'(ID_valid_o), 32'd0);
        chk("flush_squash_instr", ID_instr_o, NOP);
      end else if (prev_stall) begin
        chk("stall_hold_valid", 32'(ID_valid_o), 32'(last_valid));
        chk("stall_hold_pc", ID_pc_o, last_pc);
        chk("stall_hold_instr", ID_instr_o, last_instr);
      end else if (ID_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL id_unexpected: got pc %h instr %h, expected no instruction", ID_pc_o, ID_instr_o);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", ID_pc_o, e[63:32]);
          chk("id_instr", ID_instr_o, e[31:0]);
          chk("id_exc", 32'(ID_exc_o), 32'(e[64]));
          n_seen++;
        end
      end else begin
        chk("id_idle_nop", ID_instr_o, NOP);
      end
      last_valid = ID_valid_o;
      last_pc    = ID_pc_o;
      last_instr = ID_instr_o;
    end
  end

  task automatic step();
    @(posedge clk_i); #2;
  endtask

  task automatic wait_seen(input int n, input int budget, input string name);
    int target;
    int k;
    target = n_seen + n;
    k = 0;
    while (n_seen < target && k < budget) begin
      @(negedge clk_i); #1;
      k++;
    end
    n_checks++;
    if (n_seen < target) begin
      n_fail++;
      $display("FAIL %s: saw %0d instructions, required %0d within %0d cycles", name, n - (target - n_seen), n, budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
    repeat (3) @(negedge clk_i);
    chk("rst_req", 32'(imem_bus.imem_req_o), 32'd0);
    chk("rst_valid", 32'(ID_valid_o), 32'd0);
    chk("rst_instr", ID_instr_o, NOP);
    chk("rst_pc", ID_pc_o, 32'h0);
    chk("rst_exc", 32'(ID_exc_o), 32'd0);
    chk("rst_state", 32'(dbg_state_o), 32'd0);
    step(); rst_i = 1'b1;

    // Sequential stream with 1-cycle memory: one instruction per cycle.
    wait_seen(1, 20, "t1_first");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      chk("t1_back_to_back", 32'(ID_valid_o), 32'd1);
    end
    chk("t1_run_state", 32'(dbg_state_o), 32'd1);

    // Three-cycle stall mid-stream.
    step(); stall_i = 1'b1; stall_win = 1'b1; stall_grants = 0;
    repeat (3) step();
    stall_i = 1'b0; stall_win = 1'b0;
    chk("t2_stall_grants_bound", 32'(stall_grants <= DEPTH), 32'd1);
    wait_seen(4, 40, "t2_resume");

    // Flush with two requests in flight.
    lat_min = 3; lat_max = 3;
    k = 0;
    while (pend.size() < 2 && k < 30) begin step(); k++; end
    chk("t3_two_outstanding", 32'(pend.size()), 32'd2);
    flush_i = 1'b1; flush_pc_i = 32'h0000_0100;
    step(); flush_i = 1'b0;
    wait_seen(3, 40, "t3_after_flush");

    // Flush, stall and response in the same cycle.
    lat_min = 2; lat_max = 2;
    k = 0;
    while (!imem_bus.imem_rvalid_i && k < 20) begin step(); k++; end
    chk("t4_rvalid_present", 32'(imem_bus.imem_rvalid_i), 32'd1);
    stall_i = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h0000_0300;
    step(); flush_i = 1'b0;
    step(); stall_i = 1'b0;
    wait_seen(3, 40, "t4_after_flush");

    // Random grants and variable latency.
    gnt_rand = 1'b1; lat_min = 1; lat_max = 4;
    wait_seen(30, 800, "t5_random");
    gnt_rand = 1'b0; lat_min = 1; lat_max = 1;

    // Misaligned redirect.
    flush_i = 1'b1; flush_pc_i = 32'h0000_0102;
    step(); flush_i = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
    for (int i = 0; i < 6; i++) begin
      chk("t6_halt_no_req", 32'(imem_bus.imem_req_o), 32'd0);
      step();
    end
    chk("t6_halt_state", 32'(dbg_state_o), 32'd2);
    chk("t6_exc_presented", 32'(exp_q.size()), 32'd0);
    flush_i = 1'b1; flush_pc_i = 32'h0000_0200;
    step(); flush_i = 1'b0;
    wait_seen(3, 40, "t6_resume");
`else
    wait_seen(3, 40, "t6_forced_align");
    chk("t6_exc_tied", 32'(ID_exc_o), 32'd0);
`endif

    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
